pcm_mem_arbiter: RTL and testbench

- Four-port round-robin arbiter and sequencer that shares the single 16-bit asynchronous SRAM port (20-bit address, active-low Mem_CE/UB/LB/OE/WE) between four CPU cores.
- Each core issues one word read or write with a req/ready handshake.
- The arbiter grants one core at a time, sequences the SRAM strobes through setup, access and hold phases, and returns read data to the granted core.
- Sits between the CPU instances and the top-level SRAM tristate pins.

---
 rtl/pcm_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_pcm_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_mem_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM port between four cores.
// Each grant runs SETUP, ACCESS_CYCLES of OE/WE strobe, then DONE with a ready pulse.
module pcm_mem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned ADDR_W        = 20,
    parameter int unsigned DATA_W        = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [3:0]            cpu_req,
    input  logic [3:0]            cpu_write,
    input  logic [4*ADDR_W-1:0]   cpu_addr,
    input  logic [4*DATA_W-1:0]   cpu_wdata,
    output logic [3:0]            cpu_ready,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic [ADDR_W-1:0]     ADDR,
    output logic [DATA_W-1:0]     Data_to_mem,
    output logic                  Data_drive,
    input  logic [DATA_W-1:0]     Data_from_mem,
    output logic                  Mem_CE,
    output logic                  Mem_UB,
    output logic                  Mem_LB,
    output logic                  Mem_OE,
    output logic                  Mem_WE
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_t;

    localparam logic [3:0] CntLoad = 4'(ACCESS_CYCLES - 1);

    state_t              r_state, w_state_d;
    logic [1:0]          r_ptr, w_ptr_d;
    logic [1:0]          r_grant, w_grant_d;
    logic                r_write, w_write_d;
    logic [3:0]          r_cnt, w_cnt_d;
    logic [ADDR_W-1:0]   r_addr, w_addr_d;
    logic [DATA_W-1:0]   r_wdata, w_wdata_d;
    logic [DATA_W-1:0]   r_rdata, w_rdata_d;
    logic                r_drive, w_drive_d;
    logic                r_ce, w_ce_d;
    logic                r_oe, w_oe_d;
    logic                r_we, w_we_d;
    logic [3:0]          r_ready, w_ready_d;
    logic                r_busy, w_busy_d;

    logic                w_found;
    logic [1:0]          w_sel;
    logic [1:0]          w_idx;

    // First requesting core at or above the pointer, wrapping modulo 4.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && cpu_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_grant_d = r_grant;
        w_write_d = r_write;
        w_cnt_d   = r_cnt;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_rdata_d = r_rdata;
        w_drive_d = r_drive;
        w_ce_d    = r_ce;
        w_oe_d    = r_oe;
        w_we_d    = r_we;
        w_ready_d = 4'b0000;
        w_busy_d  = r_busy;

        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_d = StSetup;
                    w_grant_d = w_sel;
                    w_write_d = cpu_write[w_sel];
                    w_addr_d  = cpu_addr[int'(w_sel)*ADDR_W +: ADDR_W];
                    w_wdata_d = cpu_wdata[int'(w_sel)*DATA_W +: DATA_W];
                    w_drive_d = cpu_write[w_sel];
                    w_ce_d    = 1'b0;
                    w_busy_d  = 1'b1;
                end
            end
            StSetup: begin
                w_state_d = StAccess;
                w_cnt_d   = CntLoad;
                w_oe_d    = r_write;
                w_we_d    = ~r_write;
            end
            StAccess: begin
                if (r_cnt == 4'd0) begin
                    w_state_d          = StDone;
                    w_oe_d             = 1'b1;
                    w_we_d             = 1'b1;
                    w_ready_d[r_grant] = 1'b1;
                    if (!r_write) begin
                        w_rdata_d = Data_from_mem;
                    end
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            StDone: begin
                // CE, address and write data were held through DONE for hold time.
                w_state_d = StIdle;
                w_ptr_d   = r_grant + 2'd1;
                w_ce_d    = 1'b1;
                w_drive_d = 1'b0;
                w_busy_d  = 1'b0;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= StIdle;
            r_ptr   <= 2'd0;
            r_grant <= 2'd0;
            r_write <= 1'b0;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_drive <= 1'b0;
            r_ce    <= 1'b1;
            r_oe    <= 1'b1;
            r_we    <= 1'b1;
            r_ready <= 4'b0000;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_grant <= w_grant_d;
            r_write <= w_write_d;
            r_cnt   <= w_cnt_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_rdata <= w_rdata_d;
            r_drive <= w_drive_d;
            r_ce    <= w_ce_d;
            r_oe    <= w_oe_d;
            r_we    <= w_we_d;
            r_ready <= w_ready_d;
            r_busy  <= w_busy_d;
        end
    end

    assign cpu_ready   = r_ready;
    assign cpu_rdata   = r_rdata;
    assign grant       = r_grant;
    assign busy        = r_busy;
    assign ADDR        = r_addr;
    assign Data_to_mem = r_wdata;
    assign Data_drive  = r_drive;
    assign Mem_CE      = r_ce;
    assign Mem_UB      = r_ce;
    assign Mem_LB      = r_ce;
    assign Mem_OE      = r_oe;
    assign Mem_WE      = r_we;

endmodule

// File: tb/tb_pcm_mem_arbiter.sv
// Bench for pcm_mem_arbiter: transaction-phase model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pcm_mem_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int AC = 2;

    logic            Clk = 1'b0;
    logic            Reset = 1'b0;
    logic [3:0]      cpu_req, cpu_write;
    logic [4*AW-1:0] cpu_addr;
    logic [4*DW-1:0] cpu_wdata;
    logic [3:0]      cpu_ready;
    logic [DW-1:0]   cpu_rdata;
    logic [1:0]      grant;
    logic            busy;
    logic [AW-1:0]   ADDR;
    logic [DW-1:0]   Data_to_mem, Data_from_mem;
    logic            Data_drive, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    logic [3:0]      req1, write1, ready1;
    logic [4*AW-1:0] addr1;
    logic [4*DW-1:0] wdata1;
    logic [DW-1:0]   rdata1, to_mem1, from_mem1;
    logic [1:0]      grant1;
    logic [AW-1:0]   ADDR1;
    logic            busy1, drive1, ce1, ub1, lb1, oe1, we1;

    logic            force_en;
    logic [DW-1:0]   force_val;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] fmem(input logic [AW-1:0] a);
        return (a[15:0] ^ 16'h5A3C) + {12'h000, a[19:16]};
    endfunction

    assign Data_from_mem = force_en ? force_val : fmem(ADDR);
    assign from_mem1     = fmem(ADDR1);

    pcm_mem_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .Clk(Clk), .Reset(Reset), .cpu_req(cpu_req), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata), .grant(grant), .busy(busy), .ADDR(ADDR),
        .Data_to_mem(Data_to_mem), .Data_drive(Data_drive), .Data_from_mem(Data_from_mem),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    pcm_mem_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(AW), .DATA_W(DW)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .cpu_req(req1), .cpu_write(write1),
        .cpu_addr(addr1), .cpu_wdata(wdata1), .cpu_ready(ready1),
        .cpu_rdata(rdata1), .grant(grant1), .busy(busy1), .ADDR(ADDR1),
        .Data_to_mem(to_mem1), .Data_drive(drive1), .Data_from_mem(from_mem1),
        .Mem_CE(ce1), .Mem_UB(ub1), .Mem_LB(lb1), .Mem_OE(oe1), .Mem_WE(we1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        int idx;
        for (int i = 0; i < 4; i++) begin
            idx = (int'(ptr) + i) % 4;
            if (req[idx]) return 2'(idx);
        end
        return ptr;
    endfunction

    // Model: a granted transaction occupies offsets 0..AC+1 after the grant edge.
    logic          m_active;
    int            m_k;
    logic [1:0]    m_grant, m_ptr;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_active <= 1'b0; m_k <= 0; m_grant <= 2'd0; m_ptr <= 2'd0;
            m_write <= 1'b0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
        end else if (m_active) begin
            if (m_k == AC && !m_write) m_rdata <= force_en ? force_val : fmem(m_addr);
            if (m_k == AC + 1) begin
                m_active <= 1'b0;
                m_ptr    <= m_grant + 2'd1;
            end
            m_k <= m_k + 1;
        end else if (cpu_req != 4'b0000) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_grant  <= rr_pick(cpu_req, m_ptr);
            m_write  <= cpu_write[rr_pick(cpu_req, m_ptr)];
            m_addr   <= cpu_addr[int'(rr_pick(cpu_req, m_ptr))*AW +: AW];
            m_wdata  <= cpu_wdata[int'(rr_pick(cpu_req, m_ptr))*DW +: DW];
        end
    end

    always @(negedge Clk) begin
        chk("ce", Mem_CE, !m_active);
        chk("ub", Mem_UB, !m_active);
        chk("lb", Mem_LB, !m_active);
        chk("oe", Mem_OE, !(m_active && !m_write && m_k >= 1 && m_k <= AC));
        chk("we", Mem_WE, !(m_active && m_write && m_k >= 1 && m_k <= AC));
        chk("drive", Data_drive, m_active && m_write);
        chk("ready", cpu_ready, (m_active && m_k == AC + 1) ? (4'b0001 << m_grant) : 4'b0000);
        chk("busy", busy, m_active);
        chk("grant", grant, m_grant);
        chk("addr", ADDR, m_addr);
        chk("to_mem", Data_to_mem, m_wdata);
        chk("rdata", cpu_rdata, m_rdata);
    end

    task automatic step();
        logic [3:0] rdy;
        rdy = cpu_ready;
        @(posedge Clk);
        #1;
        cpu_req = cpu_req & ~rdy;
    endtask

    task automatic set_core(input int n, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        cpu_write[n]         = w;
        cpu_addr[n*AW +: AW] = a;
        cpu_wdata[n*DW +: DW] = d;
    endtask

    task automatic run_txn(input int ncyc, output int oe_lo, output int we_lo,
                           output int drv_hi, output int rc, output logic [3:0] rv,
                           output logic [DW-1:0] rd, output logic [DW-1:0] dm1,
                           output logic [DW-1:0] dmr, output logic [AW-1:0] a1);
        oe_lo = 0; we_lo = 0; drv_hi = 0; rc = -1; rv = 0; rd = 0; dm1 = 0; dmr = 0; a1 = 0;
        for (int c = 1; c <= ncyc; c++) begin
            step();
            if (!Mem_OE) oe_lo++;
            if (!Mem_WE) we_lo++;
            if (Data_drive) drv_hi++;
            if (c == 1) begin
                dm1 = Data_to_mem;
                a1  = ADDR;
            end
            if (cpu_ready != 4'b0000) begin
                rc = c; rv = cpu_ready; rd = cpu_rdata; dmr = Data_to_mem;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int oe, we, drv, rc, n, pend, requeued;
        logic [3:0] rv, r1;
        logic [DW-1:0] rd, dm1, dmr;
        logic [AW-1:0] a1;
        int ord[4];
        int cyc[4];
        logic [DW-1:0] rdv[4];
        logic [DW-1:0] exp_rd[4];

        cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
        req1 = 0; write1 = 0; addr1 = 0; wdata1 = 0;
        force_en = 1'b0; force_val = '0;
        #1 Reset = 1'b1;
        #1;
        chk("rst_ce", Mem_CE, 1); chk("rst_oe", Mem_OE, 1); chk("rst_we", Mem_WE, 1);
        chk("rst_ready", cpu_ready, 0); chk("rst_busy", busy, 0); chk("rst_addr", ADDR, 0);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        // Single read, core 2
        force_en = 1'b1; force_val = 16'hBEEF;
        set_core(2, 1'b0, 20'h12345, 16'h0000);
        cpu_req = 4'b0100;
        run_txn(6, oe, we, drv, rc, rv, rd, dm1, dmr, a1);
        chk("rd_addr", a1, 20'h12345);
        chk("rd_oe_cycles", oe, 2);
        chk("rd_we_cycles", we, 0);
        chk("rd_ready_cycle", rc, 4);
        chk("rd_ready_val", rv, 4'b0100);
        chk("rd_data", rd, 16'hBEEF);

        // Pointer now 3: cores 1 and 3 request, core 3 re-requests right after service
        set_core(1, 1'b0, 20'h00200, 16'h0000);
        set_core(3, 1'b0, 20'h00300, 16'h0000);
        cpu_req = 4'b1010;
        n = 0; pend = 0; requeued = 0;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (pend != 0) begin
                cpu_req[3] = 1'b1;
                pend = 0;
            end
            if (cpu_ready != 4'b0000 && n < 4) begin
                for (int j = 0; j < 4; j++) if (cpu_ready[j]) ord[n] = j;
                cyc[n] = c;
                if (ord[n] == 3 && requeued == 0) begin
                    pend = 1;
                    requeued = 1;
                end
                n++;
            end
        end
        chk("rr_count", n, 3);
        chk("rr_first", ord[0], 3);
        chk("rr_second", ord[1], 1);
        chk("rr_third", ord[2], 3);
        chk("rr_spacing", cyc[1] - cyc[0], 5);

        // Single write, core 0
        set_core(0, 1'b1, 20'h00010, 16'h1461);
        cpu_req = 4'b0001;
        run_txn(6, oe, we, drv, rc, rv, rd, dm1, dmr, a1);
        chk("wr_we_cycles", we, 2);
        chk("wr_oe_cycles", oe, 0);
        chk("wr_drive_cycles", drv, 4);
        chk("wr_data_setup", dm1, 16'h1461);
        chk("wr_data_hold", dmr, 16'h1461);
        chk("wr_addr", a1, 20'h00010);
        chk("wr_ready_cycle", rc, 4);
        chk("wr_ready_val", rv, 4'b0001);
        chk("wr_rdata_kept", rd, 16'hBEEF);
        force_en = 1'b0;

        // Contention from reset: all four read
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        set_core(0, 1'b0, 20'h00000, 16'h0000);
        set_core(1, 1'b0, 20'h11111, 16'h0000);
        set_core(2, 1'b0, 20'h22222, 16'h0000);
        set_core(3, 1'b0, 20'h33333, 16'h0000);
        exp_rd[0] = 16'h5A3C; exp_rd[1] = 16'h4B2E; exp_rd[2] = 16'h7820; exp_rd[3] = 16'h6912;
        cpu_req = 4'b1111;
        n = 0;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (cpu_ready != 4'b0000 && n < 4) begin
                for (int j = 0; j < 4; j++) if (cpu_ready[j]) ord[n] = j;
                cyc[n] = c;
                rdv[n] = cpu_rdata;
                n++;
            end
        end
        chk("ct_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            chk("ct_order", ord[i], i);
            chk("ct_cycle", cyc[i], 4 + 5 * i);
            chk("ct_rdata", rdv[i], exp_rd[i]);
        end

        // Reset during ACCESS of a write
        set_core(2, 1'b1, 20'h0ABCD, 16'h7777);
        cpu_req = 4'b0100;
        step();
        step();
        chk("mr_we_active", Mem_WE, 0);
        #1 Reset = 1'b1;
        #1;
        chk("mr_we", Mem_WE, 1); chk("mr_oe", Mem_OE, 1); chk("mr_ce", Mem_CE, 1);
        chk("mr_drive", Data_drive, 0); chk("mr_busy", busy, 0); chk("mr_ready", cpu_ready, 0);
        cpu_req = 4'b0000;
        @(posedge Clk);
        #1;
        chk("mr_ready_after", cpu_ready, 0);
        Reset = 1'b0;
        set_core(1, 1'b0, 20'h00F00, 16'h0000);
        cpu_req = 4'b0010;
        run_txn(6, oe, we, drv, rc, rv, rd, dm1, dmr, a1);
        chk("mr_new_cycle", rc, 4);
        chk("mr_new_val", rv, 4'b0010);
        chk("mr_new_rdata", rd, 16'h553C);
        chk("mr_new_grant", grant, 1);

        // ACCESS_CYCLES = 1 instance
        addr1[3*AW +: AW] = 20'h00ABC;
        req1 = 4'b1000;
        oe = 0; we = 0; rc = -1; rv = 0; rd = 0;
        for (int c = 1; c <= 5; c++) begin
            r1 = ready1;
            @(posedge Clk);
            #1;
            req1 = req1 & ~r1;
            if (!oe1) oe++;
            if (!we1) we++;
            if (c == 1) chk("a1_ce_setup", ce1, 0);
            if (ready1 != 4'b0000) begin
                rc = c; rv = ready1; rd = rdata1;
            end
        end
        chk("a1_oe_cycles", oe, 1);
        chk("a1_we_cycles", we, 0);
        chk("a1_ready_cycle", rc, 3);
        chk("a1_ready_val", rv, 4'b1000);
        chk("a1_rdata", rd, 16'h5080);
        chk("a1_grant", grant1, 3);
        chk("a1_idle", {busy1, drive1, ub1, lb1}, 4'b0011);
        chk("a1_addr", ADDR1, 20'h00ABC);
        chk("a1_to_mem", to_mem1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
